// File: rtl/d_scoreboard_if.sv
// Decode-side bundle for d_scoreboard: the issuing instruction, the source operands, and the stall/forwarding results.
// The decode control unit uses the master side and the scoreboard uses the slave side.
interface d_scoreboard_if #(
    parameter int NSRC  = 2,
    parameter int LAT_W = 3
);
    logic                    issue_valid;
    logic                    issue_we;
    logic [4:0]              issue_wreg;
    logic [LAT_W-1:0]        issue_tnew;
    logic                    flush;
    logic [NSRC*5-1:0]       src_addr;
    logic [NSRC*LAT_W-1:0]   src_tuse;
    logic [NSRC-1:0]         src_en;
    logic                    stall;
    logic [NSRC*3-1:0]       fwd_sel;
    logic [NSRC-1:0]         src_defer;

    modport master (
        output issue_valid, issue_we, issue_wreg, issue_tnew, flush,
        output src_addr, src_tuse, src_en,
        input  stall, fwd_sel, src_defer
    );

    modport slave (
        input  issue_valid, issue_we, issue_wreg, issue_tnew, flush,
        input  src_addr, src_tuse, src_en,
        output stall, fwd_sel, src_defer
    );
endinterface

// File: rtl/d_scoreboard.sv
// Decode-stage hazard scoreboard: keeps a registered model of the in-flight slots and produces per-source forwarding selects and one stall.
// Optional macro D_SCOREBOARD_STATS_EN adds a 32-bit stall_cnt output that counts stall cycles.
module d_scoreboard #(
    parameter int NSRC  = 2,
    parameter int DEPTH = 3,
    parameter int LAT_W = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    d_scoreboard_if.slave        bus
`ifdef D_SCOREBOARD_STATS_EN
    ,
    output logic [31:0]          stall_cnt
`endif
);

    localparam logic [LAT_W-1:0] CNT_ONE = LAT_W'(1);

    logic [DEPTH-1:0] slot_valid;
    logic [DEPTH-1:0] slot_we;
    logic [4:0]       slot_wreg [DEPTH];
    logic [LAT_W-1:0] slot_cnt  [DEPTH];

    logic [NSRC-1:0]   src_hazard;
    logic [NSRC-1:0]   defer_vec;
    logic [NSRC*3-1:0] sel_vec;
    logic              stall_int;

    // Slot 0 takes the issuing instruction; every older slot takes its younger neighbour
    // with the countdown saturating at zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            slot_valid <= '0;
            slot_we    <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                slot_wreg[k] <= '0;
                slot_cnt[k]  <= '0;
            end
        end else begin
            slot_valid[0] <= bus.issue_valid && !stall_int && !bus.flush;
            slot_we[0]    <= bus.issue_we;
            slot_wreg[0]  <= bus.issue_wreg;
            slot_cnt[0]   <= bus.issue_tnew;
            for (int k = 1; k < DEPTH; k++) begin
                slot_valid[k] <= slot_valid[k-1];
                slot_we[k]    <= slot_we[k-1];
                slot_wreg[k]  <= slot_wreg[k-1];
                slot_cnt[k]   <= (slot_cnt[k-1] == '0) ? '0 : slot_cnt[k-1] - CNT_ONE;
            end
        end
    end

    for (genvar s = 0; s < NSRC; s++) begin : g_src
        logic [4:0]       addr;
        logic [LAT_W-1:0] tuse;
        logic [DEPTH-1:0] match;
        logic             hit;
        logic [2:0]       hit_slot;
        logic [LAT_W-1:0] hit_cnt;
        logic [2:0]       sel;
        logic             defer;
        logic             hazard;

        assign addr = bus.src_addr[5*s +: 5];
        assign tuse = bus.src_tuse[LAT_W*s +: LAT_W];

        // Register 0 is hard-wired, so a zero source never matches.
        always_comb begin
            match = '0;
            for (int k = 0; k < DEPTH; k++) begin
                match[k] = bus.src_en[s] && slot_valid[k] && slot_we[k] &&
                           (slot_wreg[k] == addr) && (addr != 5'd0);
            end
        end

        // Scan from oldest to youngest so the youngest match wins.
        always_comb begin
            hit      = 1'b0;
            hit_slot = '0;
            hit_cnt  = '0;
            for (int k = DEPTH - 1; k >= 0; k--) begin
                if (match[k]) begin
                    hit      = 1'b1;
                    hit_slot = 3'(k);
                    hit_cnt  = slot_cnt[k];
                end
            end
        end

        always_comb begin
            sel    = '0;
            defer  = 1'b0;
            hazard = 1'b0;
            if (hit) begin
                if (hit_cnt == '0) begin
                    sel = hit_slot + 3'd1;
                end else if (hit_cnt <= tuse) begin
                    defer = 1'b1;
                end else begin
                    hazard = 1'b1;
                end
            end
        end

        assign sel_vec[3*s +: 3] = sel;
        assign defer_vec[s]      = defer;
        assign src_hazard[s]     = hazard;
    end

    assign stall_int     = |src_hazard;
    assign bus.stall     = stall_int;
    assign bus.fwd_sel   = sel_vec;
    assign bus.src_defer = defer_vec;

`ifdef D_SCOREBOARD_STATS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt <= '0;
        end else if (stall_int) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_d_scoreboard.sv
// Self-checking bench for d_scoreboard: directed pipeline scenarios followed by random traffic, all checked against an issue-history model.
module tb_d_scoreboard;
    localparam int NSRC  = 2;
    localparam int DEPTH = 3;
    localparam int LAT_W = 3;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    d_scoreboard_if #(.NSRC(NSRC), .LAT_W(LAT_W)) bus ();

`ifdef D_SCOREBOARD_STATS_EN
    logic [31:0] stall_cnt;
    logic [31:0] model_cnt = '0;
`endif

    d_scoreboard #(.NSRC(NSRC), .DEPTH(DEPTH), .LAT_W(LAT_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
`ifdef D_SCOREBOARD_STATS_EN
        ,
        .stall_cnt (stall_cnt)
`endif
    );

    // hist[k] is the instruction that entered E k cycles ago.
    // A result is forwardable once k reaches its tnew.
    typedef struct {
        bit v;
        bit we;
        int wreg;
        int tnew;
    } rec_t;

    rec_t hist[$];
    int   checks = 0;
    int   errors = 0;
    bit   exp_stall;
    int   exp_sel [NSRC];
    bit   exp_def [NSRC];

    function automatic void compute_expected();
        exp_stall = 1'b0;
        for (int s = 0; s < NSRC; s++) begin
            int addr;
            int tuse;
            int rem;
            bit found;
            addr = int'(bus.src_addr[5*s +: 5]);
            tuse = int'(bus.src_tuse[LAT_W*s +: LAT_W]);
            exp_sel[s] = 0;
            exp_def[s] = 1'b0;
            found = 1'b0;
            if (bus.src_en[s] && addr != 0) begin
                for (int k = 0; k < hist.size(); k++) begin
                    if (!found && hist[k].v && hist[k].we && hist[k].wreg == addr) begin
                        found = 1'b1;
                        rem = hist[k].tnew - k;
                        if (rem < 0) rem = 0;
                        if (rem == 0) exp_sel[s] = k + 1;
                        else if (rem <= tuse) exp_def[s] = 1'b1;
                        else exp_stall = 1'b1;
                    end
                end
            end
        end
    endfunction

    task automatic drive_issue(input bit v, input bit we, input int wreg, input int tnew, input bit fl);
        bus.issue_valid = v;
        bus.issue_we    = we;
        bus.issue_wreg  = 5'(wreg);
        bus.issue_tnew  = LAT_W'(tnew);
        bus.flush       = fl;
    endtask

    task automatic drive_src(input int s, input int addr, input int tuse, input bit en);
        bus.src_addr[5*s +: 5]         = 5'(addr);
        bus.src_tuse[LAT_W*s +: LAT_W] = LAT_W'(tuse);
        bus.src_en[s]                  = en;
    endtask

    task automatic idle_src();
        for (int s = 0; s < NSRC; s++) drive_src(s, 0, 0, 1'b0);
    endtask

    // Inputs have been driven at the falling edge. Check just after that, then advance the model at the rising edge.
    task automatic step(input string tag, input int want_stall = -1,
                        input int want_sel0 = -1, input int want_sel1 = -1);
        rec_t r;
        #1;
        compute_expected();
        checks++;
        assert (bus.stall === exp_stall)
        else begin
            errors++;
            $error("FAIL %s stall got %0b exp %0b", tag, bus.stall, exp_stall);
        end
        for (int s = 0; s < NSRC; s++) begin
            checks++;
            assert (bus.fwd_sel[3*s +: 3] === 3'(exp_sel[s]))
            else begin
                errors++;
                $error("FAIL %s fwd_sel%0d got %0d exp %0d", tag, s, bus.fwd_sel[3*s +: 3], exp_sel[s]);
            end
            checks++;
            assert (bus.src_defer[s] === exp_def[s])
            else begin
                errors++;
                $error("FAIL %s defer%0d got %0b exp %0b", tag, s, bus.src_defer[s], exp_def[s]);
            end
        end
        if (want_stall >= 0) begin
            checks++;
            assert (bus.stall === 1'(want_stall))
            else begin
                errors++;
                $error("FAIL %s stall_const got %0b exp %0d", tag, bus.stall, want_stall);
            end
        end
        if (want_sel0 >= 0) begin
            checks++;
            assert (bus.fwd_sel[2:0] === 3'(want_sel0))
            else begin
                errors++;
                $error("FAIL %s sel0_const got %0d exp %0d", tag, bus.fwd_sel[2:0], want_sel0);
            end
        end
        if (want_sel1 >= 0) begin
            checks++;
            assert (bus.fwd_sel[5:3] === 3'(want_sel1))
            else begin
                errors++;
                $error("FAIL %s sel1_const got %0d exp %0d", tag, bus.fwd_sel[5:3], want_sel1);
            end
        end
`ifdef D_SCOREBOARD_STATS_EN
        checks++;
        assert (stall_cnt === model_cnt)
        else begin
            errors++;
            $error("FAIL %s stall_cnt got %0d exp %0d", tag, stall_cnt, model_cnt);
        end
`endif
        @(posedge clk);
        if (reset) begin
            hist.delete();
        end else begin
            r.v    = bus.issue_valid && !exp_stall && !bus.flush;
            r.we   = bus.issue_we;
            r.wreg = int'(bus.issue_wreg);
            r.tnew = int'(bus.issue_tnew);
            hist.push_front(r);
            if (hist.size() > DEPTH) void'(hist.pop_back());
        end
`ifdef D_SCOREBOARD_STATS_EN
        if (reset) model_cnt = '0;
        else if (exp_stall) model_cnt = model_cnt + 32'd1;
`endif
        @(negedge clk);
    endtask

    task automatic drain();
        idle_src();
        drive_issue(1'b0, 1'b0, 0, 0, 1'b0);
        repeat (DEPTH) step("drain");
    endtask

    initial begin
        reset = 1'b1;
        drive_issue(1'b0, 1'b0, 0, 0, 1'b0);
        idle_src();
        @(negedge clk);
        step("rst0");
        step("rst1");
        reset = 1'b0;

        drive_src(0, 3, 1, 1'b1);
        drive_src(1, 5, 1, 1'b1);
        step("after_reset", 0, 0, 0);

        // ALU producer seen from E, M, W, and then retired
        idle_src();
        drive_issue(1'b1, 1'b1, 8, 0, 1'b0);
        step("issue_addu8");
        drive_issue(1'b0, 1'b0, 0, 0, 1'b0);
        drive_src(0, 8, 1, 1'b1);
        step("fwd_e", 0, 1, 0);
        step("fwd_m", 0, 2, 0);
        step("fwd_w", 0, 3, 0);
        step("fwd_retired", 0, 0, 0);

        // Load followed by an ALU use. The consumer also tries to issue and is held off.
        idle_src();
        drive_issue(1'b1, 1'b1, 9, 2, 1'b0);
        step("issue_lw9");
        drive_issue(1'b1, 1'b1, 10, 0, 1'b0);
        drive_src(1, 9, 1, 1'b1);
        step("lu_stall", 1, 0, 0);
        drive_issue(1'b0, 1'b0, 0, 0, 1'b0);
        step("lu_defer", 0, 0, 0);
        step("lu_fwd_w", 0, 0, 3);
        drain();

        // Load followed by a branch compare in D
        drive_issue(1'b1, 1'b1, 9, 2, 1'b0);
        step("issue_lw9b");
        drive_issue(1'b0, 1'b0, 0, 0, 1'b0);
        drive_src(0, 9, 0, 1'b1);
        step("br_stall1", 1, 0, 0);
        step("br_stall2", 1, 0, 0);
        step("br_fwd", 0, 3, 0);
        drain();

        // Two writers of $4: the youngest one wins
        drive_issue(1'b1, 1'b1, 4, 0, 1'b0);
        step("issue_addu4");
        drive_issue(1'b1, 1'b1, 4, 0, 1'b0);
        step("issue_ori4");
        drive_issue(1'b0, 1'b0, 0, 0, 1'b0);
        drive_src(0, 4, 1, 1'b1);
        step("youngest", 0, 1, 0);
        drain();

        // A write to register 0 never creates a hazard
        drive_issue(1'b1, 1'b1, 0, 2, 1'b0);
        step("issue_r0");
        drive_issue(1'b0, 1'b0, 0, 0, 1'b0);
        drive_src(0, 0, 0, 1'b1);
        drive_src(1, 0, 0, 1'b1);
        step("reg0_a", 0, 0, 0);
        step("reg0_b", 0, 0, 0);
        drain();

        // A flushed issue becomes a bubble
        drive_issue(1'b1, 1'b1, 7, 0, 1'b1);
        step("issue_flushed");
        drive_issue(1'b0, 1'b0, 0, 0, 1'b0);
        drive_src(0, 7, 1, 1'b1);
        step("flushed_nomatch", 0, 0, 0);
        drain();

        // Flush arriving while stalled
        drive_issue(1'b1, 1'b1, 9, 2, 1'b0);
        step("issue_lw9c");
        drive_issue(1'b1, 1'b1, 11, 0, 1'b1);
        drive_src(0, 9, 0, 1'b1);
        drive_src(1, 11, 0, 1'b1);
        step("flush_stall", 1, 0, 0);
        drive_issue(1'b0, 1'b0, 0, 0, 1'b0);
        step("flush_stall2", 1, 0, 0);
        step("flush_after", 0, 3, 0);
        drain();

        // Two stall cycles followed by reset. The counter reads 2, then 0.
        reset = 1'b1;
        step("pre_cnt_reset");
        reset = 1'b0;
        drive_issue(1'b1, 1'b1, 9, 2, 1'b0);
        step("issue_lw9d");
        drive_issue(1'b0, 1'b0, 0, 0, 1'b0);
        drive_src(0, 9, 0, 1'b1);
        step("cnt_stall1", 1, 0, 0);
        step("cnt_stall2", 1, 0, 0);
        reset = 1'b1;
        idle_src();
`ifdef D_SCOREBOARD_STATS_EN
        checks++;
        assert (stall_cnt === 32'd2)
        else begin
            errors++;
            $error("FAIL cnt_two got %0d exp 2", stall_cnt);
        end
`endif
        step("cnt_reset");
        reset = 1'b0;
`ifdef D_SCOREBOARD_STATS_EN
        #1;
        checks++;
        assert (stall_cnt === 32'd0)
        else begin
            errors++;
            $error("FAIL cnt_zero got %0d exp 0", stall_cnt);
        end
`endif

        // Reset arriving while stalled
        drive_issue(1'b1, 1'b1, 12, 3, 1'b0);
        step("issue_lw12");
        drive_issue(1'b0, 1'b0, 0, 0, 1'b0);
        drive_src(0, 12, 0, 1'b1);
        reset = 1'b1;
        step("rst_mid_stall", 1, 0, 0);
        reset = 1'b0;
        step("post_rst", 0, 0, 0);

        // Random traffic over a small register range, so matches are frequent
        for (int i = 0; i < 400; i++) begin
            reset = ($urandom_range(0, 63) == 0);
            drive_issue(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0),
                        int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                        1'($urandom_range(0, 7) == 0));
            for (int s = 0; s < NSRC; s++)
                drive_src(s, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                          1'($urandom_range(0, 3) != 0));
            step("rand");
        end
        reset = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
